// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcode values, decode enums and the
// layout of one buffered decode entry.
package decode_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] FUNC7_BASE = 7'b0000000;
  localparam logic [6:0] FUNC7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    IT_NONE   = 4'b0000,
    IT_R      = 4'b0001,
    IT_I_ALU  = 4'b0010,
    IT_LOAD   = 4'b0011,
    IT_STORE  = 4'b0100,
    IT_BRANCH = 4'b0101,
    IT_JAL    = 4'b0110,
    IT_JALR   = 4'b0111,
    IT_LUI    = 4'b1000,
    IT_AUIPC  = 4'b1001,
    IT_FENCE  = 4'b1010,
    IT_SYSTEM = 4'b1011
  } inst_type_e;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_U    = 3'b011,
    IMM_J    = 3'b100,
    IMM_NONE = 3'b111
  } imm_type_e;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] func3;
    logic [6:0] func7;
    inst_type_e inst_type;
    imm_type_e  imm_type;
    logic       rd_we;
    logic       illegal;
  } decoded_t;

  localparam decoded_t DECODED_RESET = '{
    opcode:    7'd0,
    rd:        5'd0,
    rs1:       5'd0,
    rs2:       5'd0,
    func3:     3'd0,
    func7:     7'd0,
    inst_type: IT_NONE,
    imm_type:  IMM_NONE,
    rd_we:     1'b0,
    illegal:   1'b0
  };

  // CSR accesses (func3 != 0) are the only SYSTEM forms that write rd.
  function automatic logic type_writes_rd(input inst_type_e t, input logic [2:0] f3);
    case (t)
      IT_R, IT_I_ALU, IT_LOAD, IT_JAL, IT_JALR, IT_LUI, IT_AUIPC: type_writes_rd = 1'b1;
      IT_SYSTEM: type_writes_rd = (f3 != 3'b000);
      default:   type_writes_rd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: builds the sign-extended immediate for each RV32I
// instruction format from the upper instruction bits.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  imm_type_e       imm_type,
  output logic [XLEN-1:0] imm
);

  logic signed [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_type)
      IMM_I: imm32 = 32'($signed(instr[31:20]));
      IMM_S: imm32 = 32'($signed({instr[31:25], instr[11:7]}));
      IMM_B: imm32 = 32'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_U: imm32 = $signed({instr[31:12], 12'b0});
      IMM_J: imm32 = 32'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      default: imm32 = '0;
    endcase
    imm = XLEN'(imm32);
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: combinational decode feeding a main
// output register plus an optional skid register for full-rate backpressure.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RVE  = 0,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic [3:0]      inst_type,
  output logic [2:0]      imm_type,
  output logic [XLEN-1:0] imm,
  output logic            rd_we,
  output logic            illegal
);

  decoded_t        dec;
  logic [XLEN-1:0] dec_imm;
  logic            use_rd, use_rs1, use_rs2, use_f3, use_f7, bad;
  logic [2:0]      f3;
  logic [6:0]      f7;

  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];

  always_comb begin
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_f3  = 1'b0;
    use_f7  = 1'b0;
    bad     = 1'b0;
    dec     = DECODED_RESET;
    dec.opcode = in_instr[6:0];
    case (in_instr[6:0])
      OPC_OP: begin
        dec.inst_type = IT_R;
        {use_rd, use_rs1, use_rs2, use_f3, use_f7} = 5'b11111;
        bad = !((f7 == FUNC7_BASE) ||
                (f7 == FUNC7_ALT && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        dec.inst_type = IT_I_ALU;
        dec.imm_type  = IMM_I;
        {use_rd, use_rs1, use_f3} = 3'b111;
        // Shift-immediates carry func7 in the upper immediate bits.
        if (f3 == 3'b001) begin
          use_f7 = 1'b1;
          bad    = (f7 != FUNC7_BASE);
        end else if (f3 == 3'b101) begin
          use_f7 = 1'b1;
          bad    = !(f7 == FUNC7_BASE || f7 == FUNC7_ALT);
        end
      end
      OPC_LOAD: begin
        dec.inst_type = IT_LOAD;
        dec.imm_type  = IMM_I;
        {use_rd, use_rs1, use_f3} = 3'b111;
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        dec.inst_type = IT_STORE;
        dec.imm_type  = IMM_S;
        {use_rs1, use_rs2, use_f3} = 3'b111;
        bad = (f3 > 3'b010);
      end
      OPC_BRANCH: begin
        dec.inst_type = IT_BRANCH;
        dec.imm_type  = IMM_B;
        {use_rs1, use_rs2, use_f3} = 3'b111;
        bad = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_JALR: begin
        dec.inst_type = IT_JALR;
        dec.imm_type  = IMM_I;
        {use_rd, use_rs1, use_f3} = 3'b111;
        bad = (f3 != 3'b000);
      end
      OPC_JAL: begin
        dec.inst_type = IT_JAL;
        dec.imm_type  = IMM_J;
        use_rd        = 1'b1;
      end
      OPC_LUI: begin
        dec.inst_type = IT_LUI;
        dec.imm_type  = IMM_U;
        use_rd        = 1'b1;
      end
      OPC_AUIPC: begin
        dec.inst_type = IT_AUIPC;
        dec.imm_type  = IMM_U;
        use_rd        = 1'b1;
      end
      OPC_MISC_MEM: begin
        dec.inst_type = IT_FENCE;
        dec.imm_type  = IMM_I;
        {use_rd, use_rs1, use_f3} = 3'b111;
      end
      OPC_SYSTEM: begin
        dec.inst_type = IT_SYSTEM;
        dec.imm_type  = IMM_I;
        {use_rd, use_rs1, use_f3} = 3'b111;
      end
      default: bad = 1'b1;
    endcase

    if (in_instr[1:0] != 2'b11) bad = 1'b1;
    if ((RVE != 0) && ((use_rd && in_instr[11]) || (use_rs1 && in_instr[19]) ||
                       (use_rs2 && in_instr[24]))) begin
      bad = 1'b1;
    end

    dec.rd    = use_rd  ? in_instr[11:7]  : 5'd0;
    dec.rs1   = use_rs1 ? in_instr[19:15] : 5'd0;
    dec.rs2   = use_rs2 ? in_instr[24:20] : 5'd0;
    dec.func3 = use_f3  ? f3 : 3'd0;
    dec.func7 = use_f7  ? f7 : 7'd0;
    dec.rd_we = type_writes_rd(dec.inst_type, f3) && (dec.rd != 5'd0);

    if (bad) begin
      dec.inst_type = IT_NONE;
      dec.imm_type  = IMM_NONE;
      dec.rd_we     = 1'b0;
      dec.illegal   = 1'b1;
    end
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr    (in_instr[31:7]),
    .imm_type (dec.imm_type),
    .imm      (dec_imm)
  );

  logic            main_valid_q, main_valid_d;
  decoded_t        main_q, main_d;
  logic [XLEN-1:0] main_pc_q, main_pc_d;
  logic [XLEN-1:0] main_imm_q, main_imm_d;
  logic            skid_valid_q, skid_valid_d;
  decoded_t        skid_q, skid_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  logic            in_ready_q, in_ready_d;
  logic            in_fire, out_fire;

  assign in_ready = (SKID != 0) ? in_ready_q : (!main_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_valid_q && out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_d       = main_q;
    main_pc_d    = main_pc_q;
    main_imm_d   = main_imm_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    skid_pc_d    = skid_pc_q;
    skid_imm_d   = skid_imm_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_fire) begin
      // in_ready is low whenever skid holds an entry, so skid and a new
      // input never compete for main.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_d       = skid_q;
        main_pc_d    = skid_pc_q;
        main_imm_d   = skid_imm_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_valid_d = 1'b1;
        main_d       = dec;
        main_pc_d    = in_pc;
        main_imm_d   = dec_imm;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_d       = dec;
      skid_pc_d    = in_pc;
      skid_imm_d   = dec_imm;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid_q <= 1'b0;
      main_q       <= DECODED_RESET;
      main_pc_q    <= '0;
      main_imm_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= DECODED_RESET;
      skid_pc_q    <= '0;
      skid_imm_q   <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_q       <= main_d;
      main_pc_q    <= main_pc_d;
      main_imm_q   <= main_imm_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      skid_pc_q    <= skid_pc_d;
      skid_imm_q   <= skid_imm_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_pc    = main_pc_q;
  assign opcode    = main_q.opcode;
  assign rd        = main_q.rd;
  assign rs1       = main_q.rs1;
  assign rs2       = main_q.rs2;
  assign func3     = main_q.func3;
  assign func7     = main_q.func7;
  assign inst_type = main_q.inst_type;
  assign imm_type  = main_q.imm_type;
  assign imm       = main_imm_q;
  assign rd_we     = main_q.rd_we;
  assign illegal   = main_q.illegal;

endmodule
